// File: rtl/alu_pkg.sv
// Shared encodings for the execution-stage ALU: ALU select codes, aluop
// values from main control, R-type funct codes and flag bit positions.
package alu_pkg;

    // ALU select driven by the ALU-control decoder.
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_e;

    // aluop as produced by the main control unit.
    typedef enum logic [1:0] {
        ALUOP_MEM   = 2'b00,  // lw/sw address add
        ALUOP_BEQ   = 2'b01,  // branch compare (subtract)
        ALUOP_RTYPE = 2'b10,  // decode funct
        ALUOP_SUB   = 2'b11   // also subtract
    } aluop_e;

    // Low four bits of the R-type funct field.
    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_AND = 4'b0100;
    localparam logic [3:0] FUNCT_OR  = 4'b0101;
    localparam logic [3:0] FUNCT_SLT = 4'b1010;

    // Bit positions inside the {N,Z,C,V} flag register.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALU-control decoder: maps {aluop, funct} to the 3-bit ALU select.
// Purely combinational so the main control unit can reuse it.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [3:0] funct,
    output logic [2:0] gout
);

    // Priority decode: aluop0 forces SUB, 00 forces ADD, 10 looks at funct.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered path holds its old value and infers a latch.
        gout = ALU_ADD;
        if (aluop[0]) begin
            gout = ALU_SUB;
        end else if (aluop == ALUOP_MEM) begin
            gout = ALU_ADD;
        end else begin
            case (funct)
                FUNCT_ADD: gout = ALU_ADD;
                FUNCT_SUB: gout = ALU_SUB;
                FUNCT_AND: gout = ALU_AND;
                FUNCT_OR:  gout = ALU_OR;
                FUNCT_SLT: gout = ALU_SLT;
                default:   gout = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/alu_32.sv
// Execution-stage arithmetic for the single-cycle datapath: ALU-control
// decode, 32-bit ALU with flags, PC+step and branch-target adders, plus a
// registered {N,Z,C,V} status register.
module alu_32
    import alu_pkg::*;
#(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  aluop,
    input  logic [3:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    input  logic [31:0] branch_offset,
    input  logic        flag_en,
    output logic [2:0]  gout,
    output logic [31:0] result,
    output logic        zero,
    output logic        neg,
    output logic        carry,
    output logic        ovf,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target,
    output logic [3:0]  flags_q
);

    logic [32:0] add_w;
    logic [32:0] sub_w;
    logic        add_ovf;
    logic        sub_ovf;
    logic [3:0]  flags_d;

    alu_ctrl_dec u_dec (
        .aluop (aluop),
        .funct (funct),
        .gout  (gout)
    );

    // Subtraction is a + ~b + 1 so its carry-out means "no unsigned borrow".
    assign add_w   = {1'b0, a} + {1'b0, b};
    assign sub_w   = {1'b0, a} + {1'b0, ~b} + 33'd1;
    assign add_ovf = (a[31] == b[31]) && (add_w[31] != a[31]);
    assign sub_ovf = (a[31] != b[31]) && (sub_w[31] != a[31]);

    // ALU result and carry/overflow selected by gout; unused codes give 0.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (gout)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result = add_w[31:0];
                carry  = add_w[32];
                ovf    = add_ovf;
            end
            ALU_SUB: begin
                result = sub_w[31:0];
                carry  = sub_w[32];
                ovf    = sub_ovf;
            end
            // Signed less-than: sign of the difference corrected by overflow.
            ALU_SLT: result = {31'b0, sub_w[31] ^ sub_ovf};
            default: result = '0;
        endcase
    end

    assign zero = (result == 32'd0);
    assign neg  = result[31];

    // PC adders wrap silently modulo 2^32.
    assign pc_plus4      = pc + PC_STEP;
    assign branch_target = pc_plus4 + branch_offset;

    // Next flag value: capture live flags when enabled, otherwise hold.
    always_comb begin
        flags_d = flags_q;
        if (flag_en) begin
            flags_d[FLAG_N] = neg;
            flags_d[FLAG_Z] = zero;
            flags_d[FLAG_C] = carry;
            flags_d[FLAG_V] = ovf;
        end
    end

    // Flag register; asynchronous reset clears it and dominates flag_en.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state updates use non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_32.sv
// Directed self-checking bench for alu_32. Each ALU vector pushes the
// reference model's expectation into a scoreboard queue when driven and
// pops it once the outputs have settled.
module tb_alu_32;

    logic        clk;
    logic        reset;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] branch_offset;
    logic        flag_en;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [3:0]  flags_q;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  gout;
        logic [31:0] result;
        logic        zero;
        logic        neg;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;

    alu_32 #(.PC_STEP(32'd4)) dut (
        .clk           (clk),
        .reset         (reset),
        .aluop         (aluop),
        .funct         (funct),
        .a             (a),
        .b             (b),
        .pc            (pc),
        .branch_offset (branch_offset),
        .flag_en       (flag_en),
        .gout          (gout),
        .result        (result),
        .zero          (zero),
        .neg           (neg),
        .carry         (carry),
        .ovf           (ovf),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target),
        .flags_q       (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written with wide/signed arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [3:0] fn,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      s;
        logic [32:0] w;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op[0])          e.gout = 3'b110;
        else if (op == 2'd0) e.gout = 3'b010;
        else begin
            case (fn)
                4'b0000: e.gout = 3'b010;
                4'b0010: e.gout = 3'b110;
                4'b0100: e.gout = 3'b000;
                4'b0101: e.gout = 3'b001;
                4'b1010: e.gout = 3'b111;
                default: e.gout = 3'b010;
            endcase
        end
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        case (e.gout)
            3'b000: e.result = x & y;
            3'b001: e.result = x | y;
            3'b010: begin
                w        = {1'b0, x} + {1'b0, y};
                e.result = w[31:0];
                e.carry  = w[32];
                s        = sx + sy;
                e.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b110: begin
                e.result = x - y;
                e.carry  = (x >= y);
                s        = sx - sy;
                e.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b111:  e.result = (sx < sy) ? 32'd1 : 32'd0;
            default: e.result = 32'd0;
        endcase
        e.zero = (e.result == 32'd0);
        e.neg  = e.result[31];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one ALU vector away from the clock edge, score it 1 time unit later.
    task automatic apply(input string tag, input logic [1:0] op, input logic [3:0] fn,
                         input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        aluop = op;
        funct = fn;
        a     = x;
        b     = y;
        sb_q.push_back(model(op, fn, x, y));
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e        = sb_q.pop_front();
            last_exp = e;
            check({tag, ".gout"},   {29'd0, gout},  {29'd0, e.gout});
            check({tag, ".result"}, result,         e.result);
            check({tag, ".zero"},   {31'd0, zero},  {31'd0, e.zero});
            check({tag, ".neg"},    {31'd0, neg},   {31'd0, e.neg});
            check({tag, ".carry"},  {31'd0, carry}, {31'd0, e.carry});
            check({tag, ".ovf"},    {31'd0, ovf},   {31'd0, e.ovf});
        end
    endtask

    task automatic apply_pc(input string tag, input logic [31:0] p, input logic [31:0] off,
                            input logic [31:0] exp_p4, input logic [31:0] exp_bt);
        @(negedge clk);
        pc            = p;
        branch_offset = off;
        #1;
        check({tag, ".pc_plus4"},      pc_plus4,      exp_p4);
        check({tag, ".branch_target"}, branch_target, exp_bt);
    endtask

    initial begin
        reset         = 1'b1;
        aluop         = 2'b00;
        funct         = 4'b0000;
        a             = '0;
        b             = '0;
        pc            = '0;
        branch_offset = '0;
        flag_en       = 1'b0;
        #1;
        check("reset.flags_q", {28'd0, flags_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Main function across the decoded operations.
        apply("radd", 2'b10, 4'b0000, 32'd5, 32'd7);
        check("radd.const", result, 32'd12);
        apply("beq_eq", 2'b01, 4'b0000, 32'h0000_1234, 32'h0000_1234);
        check("beq_eq.carry_const", {31'd0, carry}, 32'd1);
        apply("beq_ne", 2'b01, 4'b0000, 32'd3, 32'd9);
        apply("aluop11", 2'b11, 4'b0101, 32'd20, 32'd8);
        apply("rsub", 2'b10, 4'b0010, 32'h8000_0000, 32'd1);
        apply("rand", 2'b10, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00);
        apply("ror", 2'b10, 4'b0101, 32'hF0F0_1234, 32'h0FF0_FF00);
        apply("rother", 2'b10, 4'b1111, 32'hFFFF_FFFF, 32'd1);
        apply("slt_m1_1", 2'b10, 4'b1010, 32'hFFFF_FFFF, 32'd1);
        check("slt_m1_1.const", result, 32'd1);
        apply("slt_1_m1", 2'b10, 4'b1010, 32'd1, 32'hFFFF_FFFF);
        check("slt_1_m1.const", result, 32'd0);
        apply("slt_min_max", 2'b10, 4'b1010, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_min_max.const", result, 32'd1);
        apply("slt_eq", 2'b10, 4'b1010, 32'd42, 32'd42);

        // Signed overflow, then capture flags over one edge.
        apply("ovf_add", 2'b00, 4'b0000, 32'h7FFF_FFFF, 32'd1);
        check("ovf_add.const", result, 32'h8000_0000);
        @(negedge clk);
        flag_en = 1'b1;
        @(negedge clk);
        flag_en = 1'b0;
        check("flags.capture", {28'd0, flags_q}, 32'h9);

        // With flag_en low the register holds while operands change.
        apply("hold_op", 2'b10, 4'b0000, 32'd5, 32'd7);
        @(posedge clk);
        #1;
        check("flags.hold", {28'd0, flags_q}, 32'h9);

        // PC adders, including wrap-around.
        apply_pc("pc_branch", 32'h0000_001C, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0000_0010);
        apply_pc("pc_wrap", 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0000, 32'h0000_0008);

        // Reset between edges clears flags at once and leaves the ALU alone.
        apply("pre_reset", 2'b00, 4'b0000, 32'h7FFF_FFFF, 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid.flags_q", {28'd0, flags_q}, 32'h0);
        check("reset_mid.result", result, last_exp.result);

        // Reset held across an enabled edge keeps flags cleared.
        flag_en = 1'b1;
        @(posedge clk);
        #1;
        check("reset_vs_en.flags_q", {28'd0, flags_q}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        flag_en = 1'b0;
        check("post_reset.capture", {28'd0, flags_q}, 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
